// File: rtl/lsu_tagchk.sv
// lsu_tagchk: L1D tag parity check, diagnostic tag readout and error log.
//
// Pipeline: M (tag array read data arrives) -> G (parity result) -> W2
// (diagnostic readout). The error log watches the G-stage parity vector.
//
// Ports:
//   rclk, arst_l            clock, asynchronous active-low reset
//   dtag_rdata_m            per-way {parity, tag} read data (M)
//   dva_vld_m               per-way valid bits (M)
//   dtag_rd_vld_m           tag read in progress (M)
//   dtag_idx_m              set index of the read (M)
//   dtag_rsel_m             diagnostic way select, lowest set bit wins (M)
//   diag_tagrd_sel_g        request diagnostic readout (G)
//   err_clr                 clear the error log
//   lsu_rd_dtag_parity_g    per-way parity error (G)
//   diag_rdata_w2           {zeros, tag+parity, valid} (W2)
//   diag_rdata_vld_w2       one-cycle strobe for diag_rdata_w2
//   err_vld/err_way/err_idx first logged error
//   err_multi               error seen while the log was already held
//   err_cnt                 saturating count of error events
//   err_state_dbg           error log FSM state (0 = EMPTY, 1 = HELD)
module lsu_tagchk #(
  parameter int WAYS  = 4,
  parameter int TAG_W = 29,
  parameter int CHUNK = 8,
  parameter int IDX_W = 7
) (
  input  logic                      rclk,
  input  logic                      arst_l,
  input  logic [WAYS*(TAG_W+1)-1:0] dtag_rdata_m,
  input  logic [WAYS-1:0]           dva_vld_m,
  input  logic                      dtag_rd_vld_m,
  input  logic [IDX_W-1:0]          dtag_idx_m,
  input  logic [WAYS-1:0]           dtag_rsel_m,
  input  logic                      diag_tagrd_sel_g,
  input  logic                      err_clr,
  output logic [WAYS-1:0]           lsu_rd_dtag_parity_g,
  output logic [63:0]               diag_rdata_w2,
  output logic                      diag_rdata_vld_w2,
  output logic                      err_vld,
  output logic [WAYS-1:0]           err_way,
  output logic [IDX_W-1:0]          err_idx,
  output logic                      err_multi,
  output logic [7:0]                err_cnt,
  output logic                      err_state_dbg
);

  localparam int WAY_W  = TAG_W + 1;
  localparam int NCHUNK = (TAG_W + CHUNK - 1) / CHUNK;
  localparam int DIAG_W = TAG_W + 2;

  typedef enum logic {ERR_EMPTY = 1'b0, ERR_HELD = 1'b1} err_state_e;

  // ---------------- M stage ----------------
  logic [WAYS-1:0][NCHUNK-1:0] chunk_par_d, chunk_par_q;
  logic [WAYS-1:0]             stored_par_d, stored_par_q;
  logic [DIAG_W-1:0]           diag_d, diag_q;
  logic [WAYS-1:0]             dva_vld_q;
  logic                        rd_vld_q;
  logic [IDX_W-1:0]            idx_q;

  // Chunked XOR trees keep the M-stage depth short; the final fold of the
  // chunk parities with the stored bit happens in G. Bit b lands in chunk
  // b/CHUNK, so the last chunk is naturally partial.
  always_comb begin
    chunk_par_d  = '0;
    stored_par_d = '0;
    for (int w = 0; w < WAYS; w++) begin
      for (int b = 0; b < TAG_W; b++) begin
        chunk_par_d[w][b/CHUNK] = chunk_par_d[w][b/CHUNK] ^ dtag_rdata_m[w*WAY_W + b];
      end
      stored_par_d[w] = dtag_rdata_m[w*WAY_W + TAG_W];
    end
  end

  // Walk from the top way down so the lowest-index selected way wins.
  always_comb begin
    diag_d = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (dtag_rsel_m[w]) begin
        diag_d = {dtag_rdata_m[w*WAY_W +: WAY_W], dva_vld_m[w]};
      end
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      chunk_par_q  <= '0;
      stored_par_q <= '0;
      diag_q       <= '0;
      dva_vld_q    <= '0;
      rd_vld_q     <= 1'b0;
      idx_q        <= '0;
    end else begin
      chunk_par_q  <= chunk_par_d;
      stored_par_q <= stored_par_d;
      diag_q       <= diag_d;
      dva_vld_q    <= dva_vld_m;
      rd_vld_q     <= dtag_rd_vld_m;
      idx_q        <= dtag_idx_m;
    end
  end

  // ---------------- G stage ----------------
  always_comb begin
    lsu_rd_dtag_parity_g = '0;
    for (int w = 0; w < WAYS; w++) begin
      lsu_rd_dtag_parity_g[w] = ((^chunk_par_q[w]) ^ stored_par_q[w]) & rd_vld_q & dva_vld_q[w];
    end
  end

  // ---------------- W2 diagnostic readout ----------------
  logic [63:0] diag_rdata_d, diag_rdata_q;
  logic        diag_rdata_vld_d, diag_rdata_vld_q;

  always_comb begin
    diag_rdata_d     = diag_rdata_q;
    diag_rdata_vld_d = diag_tagrd_sel_g;
    if (diag_tagrd_sel_g) begin
      diag_rdata_d = 64'(diag_q);
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      diag_rdata_q     <= '0;
      diag_rdata_vld_q <= 1'b0;
    end else begin
      diag_rdata_q     <= diag_rdata_d;
      diag_rdata_vld_q <= diag_rdata_vld_d;
    end
  end

  assign diag_rdata_w2     = diag_rdata_q;
  assign diag_rdata_vld_w2 = diag_rdata_vld_q;

  // ---------------- Error log ----------------
  err_state_e       state_d, state_q;
  logic [WAYS-1:0]  err_way_d, err_way_q;
  logic [IDX_W-1:0] err_idx_d, err_idx_q;
  logic             err_multi_d, err_multi_q;
  logic [7:0]       err_cnt_d, err_cnt_q;
  logic [7:0]       cnt_inc;
  logic             err_event;

  // A multi-way failure in one cycle is a single event.
  assign err_event = |lsu_rd_dtag_parity_g;
  assign cnt_inc   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    err_way_d   = err_way_q;
    err_idx_d   = err_idx_q;
    err_multi_d = err_multi_q;
    err_cnt_d   = err_cnt_q;
    if (err_clr) begin
      // A clear that coincides with a fresh error restarts the log with it.
      if (err_event) begin
        state_d     = ERR_HELD;
        err_way_d   = lsu_rd_dtag_parity_g;
        err_idx_d   = idx_q;
        err_multi_d = 1'b0;
        err_cnt_d   = 8'd1;
      end else begin
        state_d     = ERR_EMPTY;
        err_way_d   = '0;
        err_idx_d   = '0;
        err_multi_d = 1'b0;
        err_cnt_d   = 8'd0;
      end
    end else if (err_event) begin
      case (state_q)
        ERR_EMPTY: begin
          state_d   = ERR_HELD;
          err_way_d = lsu_rd_dtag_parity_g;
          err_idx_d = idx_q;
          err_cnt_d = cnt_inc;
        end
        ERR_HELD: begin
          err_multi_d = 1'b1;
          err_cnt_d   = cnt_inc;
        end
        default: state_d = ERR_EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q     <= ERR_EMPTY;
      err_way_q   <= '0;
      err_idx_q   <= '0;
      err_multi_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      err_way_q   <= err_way_d;
      err_idx_q   <= err_idx_d;
      err_multi_q <= err_multi_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign err_vld       = (state_q == ERR_HELD);
  assign err_way       = err_way_q;
  assign err_idx       = err_idx_q;
  assign err_multi     = err_multi_q;
  assign err_cnt       = err_cnt_q;
  assign err_state_dbg = state_q;

endmodule

// File: tb/tb_lsu_tagchk.sv
// Testbench for lsu_tagchk: a default 4-way instance and an 8-way/21-bit
// instance with a partial last parity chunk. Directed vectors push their
// hand-computed expectations (stamped with the cycle they become visible)
// into queues; a negedge monitor pops and compares.
module tb_lsu_tagchk;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_l = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 4-way DUT ----------------
  logic [119:0] bus4 = '0;
  logic [3:0]   dva4 = '0, rsel4 = '0;
  logic         rdv4 = 1'b0, dsel4 = 1'b0, clr4 = 1'b0;
  logic [6:0]   idx4 = '0;
  logic [3:0]   par4, eway4;
  logic [63:0]  diag4;
  logic         diag4_vld, evld4, emulti4, est4;
  logic [6:0]   eidx4;
  logic [7:0]   ecnt4;

  lsu_tagchk u4 (
    .rclk(clk), .arst_l(arst_l),
    .dtag_rdata_m(bus4), .dva_vld_m(dva4), .dtag_rd_vld_m(rdv4),
    .dtag_idx_m(idx4), .dtag_rsel_m(rsel4), .diag_tagrd_sel_g(dsel4),
    .err_clr(clr4),
    .lsu_rd_dtag_parity_g(par4), .diag_rdata_w2(diag4),
    .diag_rdata_vld_w2(diag4_vld), .err_vld(evld4), .err_way(eway4),
    .err_idx(eidx4), .err_multi(emulti4), .err_cnt(ecnt4),
    .err_state_dbg(est4)
  );

  // ---------------- 8-way DUT ----------------
  logic [175:0] bus8 = '0;
  logic [7:0]   dva8 = '0, rsel8 = '0;
  logic         rdv8 = 1'b0, dsel8 = 1'b0, clr8 = 1'b0;
  logic [6:0]   idx8 = '0;
  logic [7:0]   par8, eway8;
  logic [63:0]  diag8;
  logic         diag8_vld, evld8, emulti8, est8;
  logic [6:0]   eidx8;
  logic [7:0]   ecnt8;

  lsu_tagchk #(.WAYS(8), .TAG_W(21), .CHUNK(8), .IDX_W(7)) u8 (
    .rclk(clk), .arst_l(arst_l),
    .dtag_rdata_m(bus8), .dva_vld_m(dva8), .dtag_rd_vld_m(rdv8),
    .dtag_idx_m(idx8), .dtag_rsel_m(rsel8), .diag_tagrd_sel_g(dsel8),
    .err_clr(clr8),
    .lsu_rd_dtag_parity_g(par8), .diag_rdata_w2(diag8),
    .diag_rdata_vld_w2(diag8_vld), .err_vld(evld8), .err_way(eway8),
    .err_idx(eidx8), .err_multi(emulti8), .err_cnt(ecnt8),
    .err_state_dbg(est8)
  );

  // ---------------- scoreboard ----------------
  localparam int K_PAR4 = 0, K_LOG4 = 1, K_DIAG4 = 2, K_PAR8 = 3;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [71:0] val;
    string       name;
  } chk_t;

  chk_t        chk_q[$];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  function automatic logic [119:0] mk4(input logic [29:0] w0, input logic [29:0] w1,
                                       input logic [29:0] w2, input logic [29:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [71:0] log_v(input logic v, input logic m, input logic [7:0] c,
                                        input logic [6:0] i, input logic [3:0] w);
    return {51'h0, v, m, c, i, w};
  endfunction

  task automatic push_chk(input int kind, input int off, input logic [71:0] val,
                          input string name);
    chk_t e;
    e.cyc  = cyc + off;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    chk_q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Monitor: compares stamped expectations, and pops a diagnostic
  // expectation on every readout strobe.
  always @(negedge clk) begin
    logic [71:0] act;
    logic [63:0] de;
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc == cyc) begin
        case (chk_q[i].kind)
          K_PAR4:  act = {68'h0, par4};
          K_LOG4:  act = {51'h0, evld4, emulti4, ecnt4, eidx4, eway4};
          K_DIAG4: act = {7'h0, diag4_vld, diag4};
          default: act = {64'h0, par8};
        endcase
        checks++;
        if (act !== chk_q[i].val) begin
          failures++;
          $display("FAIL %s @cyc %0d: got %h expected %h", chk_q[i].name, cyc, act, chk_q[i].val);
        end
        chk_q.delete(i);
      end
    end
    if (diag4_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL diag_strobe @cyc %0d: got unexpected readout %h expected none", cyc, diag4);
      end else begin
        de = exp_q.pop_front();
        if (diag4 !== de) begin
          failures++;
          $display("FAIL diag_data @cyc %0d: got %h expected %h", cyc, diag4, de);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) tick();
    // Reset values, observed while reset is still held.
    push_chk(K_PAR4, 1, 72'h0, "reset_par4");
    push_chk(K_LOG4, 1, 72'h0, "reset_log4");
    push_chk(K_DIAG4, 1, 72'h0, "reset_diag4");
    push_chk(K_PAR8, 1, 72'h0, "reset_par8");
    tick();
    arst_l = 1'b1;
    tick();

    // Bit-17 flip on way 2, but way 2 not valid: no error, log stays empty.
    bus4 = mk4(30'h0, 30'h0, 30'h0002_0000, 30'h0);
    dva4 = 4'b1011; rdv4 = 1'b1; idx4 = 7'h2A;
    push_chk(K_PAR4, 1, 72'h0, "masked_way_par");
    push_chk(K_LOG4, 2, 72'h0, "masked_way_log");
    tick();
    // Same data with all ways valid but no read in progress.
    dva4 = 4'hF; rdv4 = 1'b0;
    push_chk(K_PAR4, 1, 72'h0, "no_rd_vld_par");
    tick();

    // Bit-17 flip on way 2, idx 0x15: first error logged.
    rdv4 = 1'b1; idx4 = 7'h15;
    push_chk(K_PAR4, 1, 72'h4, "way2_flip_par");
    push_chk(K_LOG4, 2, log_v(1'b1, 1'b0, 8'd1, 7'h15, 4'b0100), "way2_flip_log");
    tick();

    // Clean tags with correct even parity (tag 0x1ABCDEF0 has 18 ones).
    bus4 = mk4(30'h0000_0003, 30'h2000_0001, 30'h0, 30'h1ABC_DEF0);
    idx4 = 7'h01;
    push_chk(K_PAR4, 1, 72'h0, "clean_tags_par");
    tick();

    // Held log: stored-parity-only flip on way 3, then ways 0 and 1
    // (way 1 flips bit 28, in the partial last chunk) in one cycle.
    bus4 = mk4(30'h0, 30'h0, 30'h0, 30'h2000_0000);
    idx4 = 7'h03;
    push_chk(K_PAR4, 1, 72'h8, "stored_bit_par");
    push_chk(K_LOG4, 2, log_v(1'b1, 1'b1, 8'd2, 7'h15, 4'b0100), "held_second_log");
    tick();
    bus4 = mk4(30'h0000_0001, 30'h1000_0000, 30'h0, 30'h0);
    idx4 = 7'h7F;
    push_chk(K_PAR4, 1, 72'h3, "multi_way_par");
    push_chk(K_LOG4, 2, log_v(1'b1, 1'b1, 8'd3, 7'h15, 4'b0100), "held_third_log");
    tick();

    // 300 more single-way errors: count saturates at 255 (reached on the
    // 252nd of these) and then holds.
    bus4 = mk4(30'h0000_0001, 30'h0, 30'h0, 30'h0);
    idx4 = 7'h09;
    for (int i = 0; i < 300; i++) begin
      if (i == 0 || i == 299) push_chk(K_PAR4, 1, 72'h1, "burst_par");
      if (i == 251) push_chk(K_LOG4, 2, log_v(1'b1, 1'b1, 8'd255, 7'h15, 4'b0100), "cnt_reach_255");
      tick();
    end
    rdv4 = 1'b0;
    push_chk(K_PAR4, 1, 72'h0, "burst_idle_par");
    push_chk(K_LOG4, 2, log_v(1'b1, 1'b1, 8'd255, 7'h15, 4'b0100), "cnt_saturated");
    tick();
    tick();

    // Clear coincident with a way-0 error reloads the log.
    rdv4 = 1'b1; idx4 = 7'h44;
    push_chk(K_PAR4, 1, 72'h1, "clr_err_par");
    push_chk(K_LOG4, 2, log_v(1'b1, 1'b0, 8'd1, 7'h44, 4'b0001), "clr_with_err_log");
    tick();
    rdv4 = 1'b0; clr4 = 1'b1;
    tick();
    // Clear with no event empties the log.
    push_chk(K_LOG4, 1, 72'h0, "plain_clr_log");
    tick();
    clr4 = 1'b0;
    tick();

    // Diagnostic readout: zero select, way 2 alone, then 1010 -> way 1.
    bus4 = mk4(30'h0, 30'h3ABC_DEF0, 30'h0002_0000, 30'h0);
    dva4 = 4'hF; rdv4 = 1'b0; rsel4 = 4'b0000;
    tick();
    dsel4 = 1'b1; rsel4 = 4'b0100;
    exp_q.push_back(64'h0);
    tick();
    rsel4 = 4'b1010;
    exp_q.push_back(64'h0000_0000_0004_0001);
    tick();
    rsel4 = 4'b0000;
    exp_q.push_back(64'h0000_0000_7579_BDE1);
    tick();
    dsel4 = 1'b0;
    push_chk(K_DIAG4, 1, {8'h00, 64'h0000_0000_7579_BDE1}, "diag_hold_1");
    push_chk(K_DIAG4, 2, {8'h00, 64'h0000_0000_7579_BDE1}, "diag_hold_2");
    tick();
    tick();

    // 8-way, 21-bit tags, chunks 0-7, 8-15, 16-20.
    dva8 = 8'hFF; rdv8 = 1'b1;
    bus8 = '0; bus8[174] = 1'b1;               // way 7 bit 20
    push_chk(K_PAR8, 1, 72'h80, "w8_way7_bit20");
    tick();
    bus8[175] = 1'b1;                          // way 7 parity restores
    push_chk(K_PAR8, 1, 72'h00, "w8_way7_good");
    tick();
    bus8 = '0; bus8[16] = 1'b1;                // way 0 bit 16
    push_chk(K_PAR8, 1, 72'h01, "w8_way0_bit16");
    tick();
    bus8 = '0; bus8[73] = 1'b1; bus8[131] = 1'b1; // way 3 bit 7, way 5 parity
    push_chk(K_PAR8, 1, 72'h28, "w8_way3_way5");
    tick();

    // Reset mid-stream: log held, readout holding data, reads in flight.
    bus4 = mk4(30'h0, 30'h0, 30'h0002_0000, 30'h0);
    rdv4 = 1'b1; idx4 = 7'h15;
    bus8 = '0; bus8[174] = 1'b1;
    tick();
    push_chk(K_PAR4, 1, 72'h0, "rst_async_par4");
    push_chk(K_LOG4, 1, 72'h0, "rst_async_log4");
    push_chk(K_DIAG4, 1, 72'h0, "rst_async_diag4");
    push_chk(K_PAR8, 1, 72'h0, "rst_async_par8");
    @(posedge clk);
    #1 arst_l = 1'b0;
    tick();
    rdv4 = 1'b0; rdv8 = 1'b0;
    tick();
    tick();
    arst_l = 1'b1;
    push_chk(K_PAR4, 1, 72'h0, "post_rst_par4");
    push_chk(K_PAR8, 1, 72'h0, "post_rst_par8");
    push_chk(K_LOG4, 2, 72'h0, "post_rst_log4");
    repeat (4) tick();

    checks++;
    if (chk_q.size() != 0) begin
      failures++;
      $display("FAIL chk_q_drain: got %0d pending expected 0", chk_q.size());
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL diag_q_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_tagchk.md
LSU_TAGCHK -- requirements
Module: lsu_tagchk

Interface
REQ-001 The block SHALL have parameter WAYS, default 4, meaning the number of L1D ways (2..8).
REQ-002 The block SHALL have parameter TAG_W, default 29, meaning tag data bits per way, excluding the parity bit (TAG_W+1 <= 63).
REQ-003 The block SHALL have parameter CHUNK, default 8, meaning the parity sub-group width in bits; the last chunk may be partial.
REQ-004 The block SHALL have parameter IDX_W, default 7, meaning the width of the tag-array set index.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-006 rclk  in  1  clock; all flops are posedge.
REQ-007 arst_l  in  1  asynchronous active-low reset.
REQ-008 dtag_rdata_m  in  WAYS*(TAG_W+1)  tag read data; way w occupies [w*(TAG_W+1) +: TAG_W+1]; its MSB is stored parity.
REQ-009 dva_vld_m  in  WAYS  valid-array bits per way.
REQ-010 dtag_rd_vld_m  in  1  a tag read is in progress this cycle.
REQ-011 dtag_idx_m  in  IDX_W  set index of the read.
REQ-012 dtag_rsel_m  in  WAYS  diagnostic way select, expected one-hot.
REQ-013 diag_tagrd_sel_g  in  1  request diagnostic readout of the selected way.
REQ-014 err_clr  in  1  clear the error log.
REQ-015 lsu_rd_dtag_parity_g  out  WAYS  per-way parity error in G.
REQ-016 diag_rdata_w2  out  64  diagnostic readout: {zeros, tag+parity, valid}.
REQ-017 diag_rdata_vld_w2  out  1  diag_rdata_w2 is valid.
REQ-018 err_vld  out  1  the error log holds an error.
REQ-019 err_way  out  WAYS  way mask of the first logged error.
REQ-020 err_idx  out  IDX_W  set index of the first logged error.
REQ-021 err_multi  out  1  an error occurred while the log was already full.
REQ-022 err_cnt  out  8  saturating count of error events.

Function
REQ-023 The M stage SHALL compute per-way XOR reductions over ceil(TAG_W/CHUNK) chunks of tag data bits.
- Chunk k covers bits [min(k*CHUNK+CHUNK-1, TAG_W-1) : k*CHUNK].
REQ-024 The M-to-G pipeline register SHALL hold, per way: the chunk parities, the stored parity bit, dva_vld_m, dtag_rd_vld_m and dtag_idx_m.
REQ-025 lsu_rd_dtag_parity_g[w] SHALL be the XOR of the registered chunk parities and stored parity, ANDed with the registered rd_vld and dva_vld[w].
- Latency: one rclk after the M inputs.
REQ-026 The diagnostic mux in M SHALL select the lowest-index set bit of dtag_rsel_m.
- Output: {tag+parity, dva_vld}.
- If dtag_rsel_m is zero, the output SHALL be all zeros.
- The result SHALL be registered into G.
REQ-027 When diag_tagrd_sel_g=1, the next rclk SHALL load diag_rdata_w2 = {zero-extend, tag_g, vld_g} and set diag_rdata_vld_w2=1 for exactly one cycle.
- Otherwise diag_rdata_w2 SHALL hold its value and diag_rdata_vld_w2=0.
REQ-028 The error log SHALL be a two-state FSM: EMPTY and HELD. An error event is a cycle in which lsu_rd_dtag_parity_g != 0.
REQ-029 In EMPTY, an error event SHALL move the FSM to HELD on the next rclk.
- Loads: err_way = parity vector, err_idx = registered index, err_cnt += 1, err_vld = 1.
REQ-030 In HELD, an error event SHALL set err_multi=1 and increment err_cnt.
- err_way and err_idx SHALL NOT change.
REQ-031 err_cnt SHALL saturate at 255 and never wrap.
REQ-032 err_clr without an error event SHALL return the FSM to EMPTY.
- Clears: err_vld, err_way, err_idx, err_multi, err_cnt.
REQ-033 err_clr in the same cycle as an error event SHALL reload the log with the new error.
- State HELD, err_multi = 0, err_cnt = 1.
REQ-034 A multi-way error in one cycle SHALL count as one event; err_way SHALL record all failing ways.

Reset
REQ-035 While arst_l=0, all flops SHALL clear asynchronously.
- Outputs: lsu_rd_dtag_parity_g=0, diag_rdata_w2=0, diag_rdata_vld_w2=0, err_vld=0, err_way=0, err_idx=0, err_multi=0, err_cnt=0; FSM=EMPTY.
REQ-036 Reset asserted mid-operation SHALL discard in-flight G and W2 data; no error SHALL be logged from a read whose M cycle preceded reset release.

Verification
REQ-037 Way 2 has a single-bit flip in tag bit 17, dva_vld_m=4'hF, rd_vld=1, idx=0x15.
- Next cycle: lsu_rd_dtag_parity_g=4'b0100.
- Following cycle: err_vld=1, err_way=4'b0100, err_idx=0x15, err_cnt=1.
REQ-038 Same flip on way 2 but dva_vld_m[2]=0 -> parity_g=0 and the log stays EMPTY.
REQ-039 Two error reads after the log is held -> err_way and err_idx unchanged, err_multi=1, err_cnt=3.
- Then 300 more error events -> err_cnt=255.
REQ-040 err_clr coincident with a way-0 error -> err_way=4'b0001, err_multi=0, err_cnt=1.
REQ-041 dtag_rsel_m=4'b1010, way 1 tag=0x1ABCDEF0 with parity 1, vld=1, diag_tagrd_sel_g=1 in G.
- Next cycle: diag_rdata_w2 = {33'h0, 1'b1, 29'h1ABCDEF0, 1'b1}, vld for one cycle.
REQ-042 Run WAYS=8, TAG_W=21, CHUNK=8 (partial last chunk of 5 bits).
- A flip in bit 20 of way 7 -> lsu_rd_dtag_parity_g=8'h80.
- Assert arst_l mid-stream -> all outputs are 0 immediately.
